// File: rtl/display_refresh_scheduler_if.sv
// RTC read-port bundle between the refresh scheduler and the RTC bus controller.
interface display_refresh_scheduler_if;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;

  // Scheduler side issues requests, controller side returns strobed data.
  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/display_refresh_scheduler.sv
// Periodically reads RTC time/date/timer registers into a shadow bank of BCD
// digits and commits the bank to the screen only at a vsync falling edge.
module display_refresh_scheduler #(
  parameter int unsigned FRAMES_PER_UPDATE = 30,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               vsync,
  input  logic                               hold,
  display_refresh_scheduler_if.master        rd_bus,
  output logic [3:0]                         digit0_HH,
  output logic [3:0]                         digit1_HH,
  output logic [3:0]                         digit0_MM,
  output logic [3:0]                         digit1_MM,
  output logic [3:0]                         digit0_SS,
  output logic [3:0]                         digit1_SS,
  output logic [3:0]                         digit0_DAY,
  output logic [3:0]                         digit1_DAY,
  output logic [3:0]                         digit0_MES,
  output logic [3:0]                         digit1_MES,
  output logic [3:0]                         digit0_YEAR,
  output logic [3:0]                         digit1_YEAR,
  output logic [3:0]                         digit0_HH_T,
  output logic [3:0]                         digit1_HH_T,
  output logic [3:0]                         digit0_MM_T,
  output logic [3:0]                         digit1_MM_T,
  output logic [3:0]                         digit0_SS_T,
  output logic [3:0]                         digit1_SS_T,
  output logic                               AM_PM,
  output logic                               update_done,
  output logic                               rd_error
);

  localparam int unsigned NUM_READS = 9;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [IDX_W-1:0] IDX_HH   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_READS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAMES_PER_UPDATE - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_REQ         = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK    = 2'd2;
  localparam logic [1:0] ST_PEND_COMMIT = 2'd3;

  logic [1:0]                           state_q, state_d;
  logic                                 vsync_q;
  logic [CNT_W-1:0]                     frame_cnt_q;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [CNT_W-1:0]                     tmo_q, tmo_d;
  logic                                 rd_req_q, rd_req_d;
  logic [BYTE_W-1:0]                    rd_addr_q, rd_addr_d;
  logic [NUM_READS-1:0][BYTE_W-1:0]     shadow_q, shadow_d;
  logic                                 shadow_ampm_q, shadow_ampm_d;
  logic [NUM_READS-1:0][BYTE_W-1:0]     disp_q, disp_d;
  logic                                 am_pm_q, am_pm_d;
  logic                                 update_done_q, update_done_d;
  logic                                 rd_error_q, rd_error_d;

  logic fall;
  logic frame_wrap;
  logic ack_c;

  // RTC register address for each slot of the fixed read order.
  function automatic logic [BYTE_W-1:0] read_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): return 8'h21;  // SS
      IDX_W'(1): return 8'h22;  // MM
      IDX_W'(2): return 8'h23;  // HH
      IDX_W'(3): return 8'h24;  // DAY
      IDX_W'(4): return 8'h25;  // MES
      IDX_W'(5): return 8'h26;  // YEAR
      IDX_W'(6): return 8'h41;  // SS_T
      IDX_W'(7): return 8'h42;  // MM_T
      IDX_W'(8): return 8'h43;  // HH_T
      default:   return 8'h00;
    endcase
  endfunction

  // {tens, units}; the hours register carries a 12h tens bit and the PM flag above it.
  function automatic logic [BYTE_W-1:0] decode_reg(input logic [IDX_W-1:0] idx,
                                                  input logic [BYTE_W-1:0] data);
    if (idx == IDX_HH) return {3'b000, data[4], data[3:0]};
    return data;
  endfunction

  assign fall       = vsync_q & ~vsync;
  assign frame_wrap = fall && (frame_cnt_q == FRAME_LAST);
  assign ack_c      = rd_bus.rd_ack & rd_req_q;

  // Vsync edge detector and frame counter; counts regardless of FSM state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= vsync;
      if (fall) begin
        frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and next-output logic for the read/commit sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    shadow_d      = shadow_q;
    shadow_ampm_d = shadow_ampm_q;
    disp_d        = disp_q;
    am_pm_d       = am_pm_q;
    update_done_d = 1'b0;
    rd_error_d    = rd_error_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_wrap && !hold) begin
          idx_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        rd_req_d  = 1'b1;
        rd_addr_d = read_addr(idx_q);
        tmo_d     = '0;
        state_d   = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (ack_c) begin
          shadow_d[idx_q] = decode_reg(idx_q, rd_bus.rd_data);
          if (idx_q == IDX_HH) shadow_ampm_d = rd_bus.rd_data[5];
          rd_req_d = 1'b0;
          if (hold) begin
            state_d = ST_IDLE;
          end else if (idx_q == IDX_LAST) begin
            state_d = ST_PEND_COMMIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_REQ;
          end
        end else if (tmo_q == TMO_LIMIT) begin
          rd_req_d   = 1'b0;
          rd_error_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      ST_PEND_COMMIT: begin
        // The commit edge returns to IDLE, so it can never also start a sequence.
        if (fall) begin
          disp_d        = shadow_q;
          am_pm_d       = shadow_ampm_q;
          update_done_d = 1'b1;
          rd_error_d    = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      shadow_q      <= '0;
      shadow_ampm_q <= 1'b0;
      disp_q        <= '0;
      am_pm_q       <= 1'b0;
      update_done_q <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      shadow_q      <= shadow_d;
      shadow_ampm_q <= shadow_ampm_d;
      disp_q        <= disp_d;
      am_pm_q       <= am_pm_d;
      update_done_q <= update_done_d;
      rd_error_q    <= rd_error_d;
    end
  end

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;

  assign {digit1_SS,   digit0_SS}   = disp_q[0];
  assign {digit1_MM,   digit0_MM}   = disp_q[1];
  assign {digit1_HH,   digit0_HH}   = disp_q[2];
  assign {digit1_DAY,  digit0_DAY}  = disp_q[3];
  assign {digit1_MES,  digit0_MES}  = disp_q[4];
  assign {digit1_YEAR, digit0_YEAR} = disp_q[5];
  assign {digit1_SS_T, digit0_SS_T} = disp_q[6];
  assign {digit1_MM_T, digit0_MM_T} = disp_q[7];
  assign {digit1_HH_T, digit0_HH_T} = disp_q[8];

  assign AM_PM       = am_pm_q;
  assign update_done = update_done_q;
  assign rd_error    = rd_error_q;

endmodule

// File: tb/tb_display_refresh_scheduler.sv
// Randomized bench for display_refresh_scheduler with a transaction-level model.
module tb_display_refresh_scheduler;

  localparam int FPU = 2;
  localparam int TMO = 4;
  localparam logic [7:0] ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                      8'h26, 8'h41, 8'h42, 8'h43};
  localparam logic [7:0] FIXED [9] = '{8'h59, 8'h07, 8'h32, 8'h31, 8'h12,
                                       8'h16, 8'h00, 8'h05, 8'h01};

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic vsync = 1'b1;
  logic hold  = 1'b0;

  logic [3:0] digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS;
  logic [3:0] digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR;
  logic [3:0] digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T;
  logic       AM_PM, update_done, rd_error;
  logic [71:0] obs_digits;

  display_refresh_scheduler_if bus ();

  display_refresh_scheduler #(.FRAMES_PER_UPDATE(FPU), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .hold(hold), .rd_bus(bus),
    .digit0_HH(digit0_HH), .digit1_HH(digit1_HH), .digit0_MM(digit0_MM), .digit1_MM(digit1_MM),
    .digit0_SS(digit0_SS), .digit1_SS(digit1_SS), .digit0_DAY(digit0_DAY), .digit1_DAY(digit1_DAY),
    .digit0_MES(digit0_MES), .digit1_MES(digit1_MES), .digit0_YEAR(digit0_YEAR),
    .digit1_YEAR(digit1_YEAR), .digit0_HH_T(digit0_HH_T), .digit1_HH_T(digit1_HH_T),
    .digit0_MM_T(digit0_MM_T), .digit1_MM_T(digit1_MM_T), .digit0_SS_T(digit0_SS_T),
    .digit1_SS_T(digit1_SS_T), .AM_PM(AM_PM), .update_done(update_done), .rd_error(rd_error)
  );

  assign obs_digits = {digit1_SS, digit0_SS, digit1_MM, digit0_MM, digit1_HH, digit0_HH,
                       digit1_DAY, digit0_DAY, digit1_MES, digit0_MES, digit1_YEAR, digit0_YEAR,
                       digit1_SS_T, digit0_SS_T, digit1_MM_T, digit0_MM_T, digit1_HH_T, digit0_HH_T};

  always #5 clock = ~clock;

  // Model state: what the screen should show and where the scheduler is in its cycle.
  int         n_checks = 0;
  int         n_err    = 0;
  int         falls    = 0;
  logic [7:0] disp   [9];
  logic [7:0] shadow [9];
  logic [7:0] mem    [9];
  logic       disp_ampm   = 1'b0;
  logic       shadow_ampm = 1'b0;
  logic       err_m       = 1'b0;
  bit         pending     = 1'b0;
  bit         first_seq   = 1'b1;
  bit         did_reset   = 1'b0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [71:0] exp_digits();
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], disp[i]};
    return v;
  endfunction

  function automatic logic [7:0] bcd_decode(input int idx, input logic [7:0] d);
    logic [3:0] tens = (idx == 2) ? {3'b000, d[4]} : d[7:4];
    return {tens, d[3:0]};
  endfunction

  task automatic model_reset();
    falls = 0; pending = 0; err_m = 0; disp_ampm = 0; shadow_ampm = 0;
    for (int i = 0; i < 9; i++) begin disp[i] = '0; shadow[i] = '0; end
  endtask

  // Drive one full read sequence from the REQ state, acting as the RTC controller.
  task automatic run_sequence(input int hold_at, input int to_at, input bit rst_mid);
    int lat;
    for (int i = 0; i < 9; i++) mem[i] = first_seq ? FIXED[i] : 8'($urandom);
    first_seq = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("req_rise", bus.rd_req, 1);
      check("req_addr", bus.rd_addr, ADDR[i]);
      if (rst_mid) begin
        #1 reset = 1'b0;
        #1;
        check("rst_req", bus.rd_req, 0);
        check("rst_digits", obs_digits, 0);
        check("rst_ampm", AM_PM, 0);
        check("rst_error", rd_error, 0);
        model_reset();
        did_reset = 1;
        tick();
        reset = 1'b1;
        tick();
        return;
      end
      if (i == to_at) begin
        for (int k = 1; k <= TMO; k++) begin
          tick();
          check("to_req_held", bus.rd_req, 1);
        end
        tick();
        check("to_req_drop", bus.rd_req, 0);
        err_m = 1;
        check("to_error", rd_error, err_m);
        check("to_digits_kept", obs_digits, exp_digits());
        check("to_ampm_kept", AM_PM, disp_ampm);
        return;
      end
      lat = int'($urandom_range(4, 2));
      if (i == hold_at) hold = 1'b1;
      for (int k = 1; k < lat; k++) begin
        tick();
        check("wait_req_held", bus.rd_req, 1);
        check("wait_addr_stable", bus.rd_addr, ADDR[i]);
      end
      bus.rd_ack  = 1'b1;
      bus.rd_data = mem[i];
      tick();
      bus.rd_ack  = 1'b0;
      bus.rd_data = 8'($urandom);
      check("req_drop", bus.rd_req, 0);
      shadow[i] = bcd_decode(i, mem[i]);
      if (i == 2) shadow_ampm = mem[i][5];
      if (hold) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          check("hold_no_req", bus.rd_req, 0);
        end
        hold = 1'b0;
        return;
      end
    end
    pending = 1;
  endtask

  // One vsync fall, then whatever the model says that fall should cause.
  task automatic frame_step(input bit hold_fall, input int hold_at, input int to_at,
                            input bit rst_mid);
    bit wrap;
    check("pre_fall_digits", obs_digits, exp_digits());
    check("pre_fall_error", rd_error, err_m);
    hold  = hold_fall;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    hold  = 1'b0;
    falls++;
    wrap = (falls % FPU) == 0;
    if (pending) begin
      for (int i = 0; i < 9; i++) disp[i] = shadow[i];
      disp_ampm = shadow_ampm;
      err_m     = 0;
      pending   = 0;
      check("commit_pulse", update_done, 1);
      check("commit_digits", obs_digits, exp_digits());
      check("commit_ampm", AM_PM, disp_ampm);
      check("commit_error_clr", rd_error, 0);
      tick();
      check("done_one_cycle", update_done, 0);
      tick();
      check("no_start_on_commit", bus.rd_req, 0);
    end else if (wrap && !hold_fall) begin
      check("start_req_low", bus.rd_req, 0);
      check("start_no_done", update_done, 0);
      run_sequence(hold_at, to_at, rst_mid);
    end else begin
      check("idle_no_done", update_done, 0);
      tick();
      tick();
      check("idle_no_req", bus.rd_req, 0);
    end
  endtask

  // Idle gap with occasional stray acks that must be ignored.
  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        bus.rd_ack  = 1'b1;
        bus.rd_data = 8'($urandom);
      end
      tick();
      bus.rd_ack = 1'b0;
      check("gap_no_req", bus.rd_req, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_data = 8'h00;
    model_reset();
    for (int i = 0; i < 9; i++) mem[i] = '0;
    repeat (3) tick();
    check("reset_req", bus.rd_req, 0);
    check("reset_addr", bus.rd_addr, 0);
    check("reset_digits", obs_digits, 0);
    check("reset_ampm", AM_PM, 0);
    check("reset_done", update_done, 0);
    check("reset_error", rd_error, 0);
    reset = 1'b1;
    tick();
    gap(3);

    // Normal refresh with the fixed register image.
    frame_step(0, 9, 9, 0);
    gap(2);
    frame_step(0, 9, 9, 0);
    gap(5);
    frame_step(0, 9, 9, 0);
    check("ss_tens", digit1_SS, 5);
    check("ss_units", digit0_SS, 9);
    check("hh_tens", digit1_HH, 1);
    check("hh_units", digit0_HH, 2);
    check("am_pm", AM_PM, 1);
    check("year_tens", digit1_YEAR, 1);
    check("year_units", digit0_YEAR, 6);
    gap(2);

    // Timeout on the 4th read, then a clean sequence that clears the error.
    frame_step(0, 9, 3, 0);
    gap(2);
    frame_step(0, 9, 9, 0);
    gap(2);
    frame_step(0, 9, 9, 0);
    gap(2);
    frame_step(0, 9, 9, 0);
    gap(2);

    // Hold raised during read 3, then hold high across a wrap.
    frame_step(0, 2, 9, 0);
    gap(2);
    frame_step(0, 9, 9, 0);
    gap(2);
    frame_step(1, 9, 9, 0);
    gap(2);

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      bit hf = ($urandom_range(7, 0) == 0);
      int ha = ($urandom_range(4, 0) == 0) ? int'($urandom_range(8, 0)) : 9;
      int ta = ($urandom_range(4, 0) == 0) ? int'($urandom_range(8, 0)) : 9;
      frame_step(hf, ha, ta, 0);
      gap(int'($urandom_range(4, 1)));
    end

    // Asynchronous reset while a read is outstanding, then restart from scratch.
    for (int it = 0; it < 6 && !did_reset; it++) begin
      frame_step(0, 9, 9, 1);
      gap(2);
    end
    check("reset_test_reached", did_reset, 1);
    gap(2);
    for (int it = 0; it < FPU + 1; it++) begin
      frame_step(0, 9, 9, 0);
      gap(2);
    end
    check("final_digits", obs_digits, exp_digits());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
